// File: rtl/sync_fifo_if.sv
// Streaming handshake bundle for sync_fifo: producer-side write channel and
// consumer-side read channel.
//
// Handshake rules (both channels): a word moves on a rising clock edge
// exactly when valid and ready are both 1 in the cycle before that edge.
// The source holds valid and data stable until the transfer happens. Ready
// may change in any cycle and does not depend on valid.
interface sync_fifo_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;

  // Environment side: drives writes and consumes reads.
  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready,
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

  // FIFO side.
  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready,
    output rd_valid,
    output rd_data,
    input  rd_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO built around a dual-port RAM with a registered read port.
// The RAM output register acts as the head slot. rd_valid marks when that
// slot holds the oldest word.

// Simple dual-port RAM: port A writes, port B reads through an output register
// that holds its value while ren is low.
module dpram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dina,
  input  logic             ren,
  input  logic [AW-1:0]    addrb,
  output logic [WIDTH-1:0] doutb
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port A.
  always_ff @(posedge clk) begin
    if (wen) mem[addra] <= dina;
  end

  // Registered read port B; output holds while not reading.
  always_ff @(posedge clk) begin
    if (ren) doutb <= mem[addrb];
  end
endmodule

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AFULL = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     rst,
  sync_fifo_if.slave               bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AFULL);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_occ;   // words in RAM not yet moved to the head register
  logic [AW:0]   count_q;
  logic          head_valid;

  logic push;
  logic pop;
  logic issue;

  // Handshake decode. wr_ready comes from count_q only, so there is no
  // combinational path from rd_ready; a pop while full does not admit a push.
  always_comb begin
    bus.wr_ready = (count_q != FULL_CNT);
    push         = bus.wr_valid & bus.wr_ready;
    pop          = head_valid & bus.rd_ready;
    // Refill the head whenever it is empty or being consumed this cycle.
    // A word written this cycle is not yet counted in ram_occ, so the read
    // can never hit the address being written.
    issue        = (ram_occ != '0) & (~head_valid | bus.rd_ready);
  end

  dpram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .wen  (push),
    .addra(wr_ptr),
    .dina (bus.wr_data),
    .ren  (issue),
    .addrb(rd_ptr),
    .doutb(bus.rd_data)
  );

  // Pointers wrap modulo DEPTH through natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // RAM occupancy: +1 on write, -1 when a word moves to the head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_occ <= '0;
    end else begin
      case ({push, issue})
        2'b10:   ram_occ <= ram_occ + ONE;
        2'b01:   ram_occ <= ram_occ - ONE;
        default: ram_occ <= ram_occ;
      endcase
    end
  end

  // Head flag: set by a refill, cleared by a pop that has no refill behind it.
  always_ff @(posedge clk) begin
    if (rst)        head_valid <= 1'b0;
    else if (issue) head_valid <= 1'b1;
    else if (pop)   head_valid <= 1'b0;
  end

  // Total word count (RAM plus head), tracked directly from push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output flags decoded from registered state.
  always_comb begin
    bus.rd_valid = head_valid;
    count        = count_q;
    almost_full  = (count_q >= AF_CNT);
  end
endmodule
